countdown_sched: RTL

//  - Controller for the 7-digit BCD countdown datapath (HH:MM:SS.t) used by the lock lockout timer and the user alarm.
//  - Accepts a load request, checks it is valid BCD, and arbitrates start/pause/abort commands.
//  - Generates the internal 10 Hz tick, performs the borrow-chain decrement and reports completion.
//  - Sits between the UART command decoder / lock FSM and the 7-seg scan logic.

---
 rtl/countdown_pkg.sv | 49 ++++
 rtl/tick_gen.sv | 37 +++
 rtl/countdown_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - state encodings, BCD digit limits and load validity check
package countdown_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

    localparam int DIG_T      = 0;
    localparam int DIG_S1     = 1;
    localparam int DIG_S10    = 2;
    localparam int DIG_M1     = 3;
    localparam int DIG_M10    = 4;
    localparam int DIG_H1     = 5;
    localparam int DIG_H10    = 6;
    localparam int NUM_DIGITS = 7;

    // Value a digit takes when a borrow passes through it.
    function automatic logic [3:0] digit_limit(input int idx);
        if (idx == DIG_S10 || idx == DIG_M10) begin
            return BCD_MAX_TENS;
        end
        return BCD_MAX;
    endfunction

    function automatic logic bcd_valid(input logic [27:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*4 +: 4] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        if (v[DIG_M10*4 +: 4] > BCD_MAX_TENS) begin
            ok = 1'b0;
        end
        if (v[DIG_S10*4 +: 4] > BCD_MAX_TENS) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - TICK_DIV prescaler producing a one-cycle tick while enabled
module tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_sched.sv
// rtl/countdown_sched.sv - BCD countdown FSM, borrow chain and load checker; COUNTDOWN_AUTORELOAD_EN adds shadow reload
module countdown_sched
    import countdown_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [27:0] load_time,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    output logic [27:0] time_out,
    output logic [2:0]  state_o,
    output logic        running,
    output logic        done,
    output logic        load_err
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    state_t      state_q, state_d;
    logic [27:0] time_q, time_d;
    logic        done_q, done_d;
    logic        load_err_q, load_err_d;
    logic        running_q, running_d;

    logic        tick;
    logic        tick_clr;
    logic        load_acc;
    logic        reload_ok;
    logic [27:0] dec_time;
    logic        borrow;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [27:0] shadow_q, shadow_d;
    assign reload_ok = (shadow_q != '0);
`else
    assign reload_ok = 1'b0;
`endif

    // Holding the prescaler clear throughout ARMED gives a fresh period on every start from ARMED.
    assign tick_clr = abort || (state_q == ST_ARMED);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .en  (state_q == ST_RUN),
        .tick(tick)
    );

    always_comb begin
        dec_time = time_q;
        borrow   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (time_q[i*4 +: 4] == 4'd0) begin
                    dec_time[i*4 +: 4] = digit_limit(i);
                end else begin
                    dec_time[i*4 +: 4] = time_q[i*4 +: 4] - 4'd1;
                    borrow             = 1'b0;
                end
            end
        end
    end

    assign load_acc = load_valid && load_ready;

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        shadow_d   = shadow_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
            time_d  = '0;
        end else if (load_acc) begin
            if (bcd_valid(load_time)) begin
                time_d  = load_time;
                state_d = ST_ARMED;
`ifdef COUNTDOWN_AUTORELOAD_EN
                shadow_d = load_time;
`endif
            end else begin
                load_err_d = 1'b1;
            end
        end else if (start && (state_q == ST_ARMED || state_q == ST_PAUSE)) begin
            if (time_q != '0) begin
                state_d = ST_RUN;
            end else if (state_q == ST_ARMED) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end else if (pause && state_q == ST_RUN) begin
            state_d = ST_PAUSE;
        end else if (tick && state_q == ST_RUN) begin
            time_d = dec_time;
            if (dec_time == '0) begin
                done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                if (reload_ok) begin
                    time_d = shadow_q;
                end else begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_DONE;
`endif
            end
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
            running_q  <= running_d;
        end
    end

`ifdef COUNTDOWN_AUTORELOAD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    assign load_ready = (state_q != ST_RUN);
    assign time_out   = time_q;
    assign state_o    = state_q;
    assign running    = running_q;
    assign done       = done_q;
    assign load_err   = load_err_q;

endmodule
